// File: rtl/l1a_bx_tagger_if.sv
// Command-decoder inputs and DAQ-side tag/FIFO outputs of the L1A/BX tagger.
// BC0_ERR/BC0_ERRCNT exist only when BC0_CHECK_EN is defined.
`timescale 1ns/1ps
interface l1a_bx_tagger_if #(parameter int DEPTH_LOG2 = 3);
    logic                  CLKENA;
    logic                  BC0;
    logic                  BXRST;
    logic                  L1ARST;
    logic                  L1ASRST;
    logic                  L1A;
    logic                  RD_EN;
    logic [11:0]           BXCNT;
    logic [23:0]           L1ACNT;
    logic [35:0]           DOUT;
    logic                  EMPTY;
    logic                  FULL;
    logic [DEPTH_LOG2:0]   COUNT;
    logic                  OVF;
`ifdef BC0_CHECK_EN
    logic                  BC0_ERR;
    logic [7:0]            BC0_ERRCNT;

    modport master (output CLKENA, BC0, BXRST, L1ARST, L1ASRST, L1A, RD_EN,
                    input  BXCNT, L1ACNT, DOUT, EMPTY, FULL, COUNT, OVF, BC0_ERR, BC0_ERRCNT);
    modport slave  (input  CLKENA, BC0, BXRST, L1ARST, L1ASRST, L1A, RD_EN,
                    output BXCNT, L1ACNT, DOUT, EMPTY, FULL, COUNT, OVF, BC0_ERR, BC0_ERRCNT);
`else
    modport master (output CLKENA, BC0, BXRST, L1ARST, L1ASRST, L1A, RD_EN,
                    input  BXCNT, L1ACNT, DOUT, EMPTY, FULL, COUNT, OVF);
    modport slave  (input  CLKENA, BC0, BXRST, L1ARST, L1ASRST, L1A, RD_EN,
                    output BXCNT, L1ACNT, DOUT, EMPTY, FULL, COUNT, OVF);
`endif
endinterface

// File: rtl/l1a_bx_tagger.sv
// BX/L1A counters tagging each accepted L1A into a FWFT FIFO; BC0_CHECK_EN adds a BC0 alignment check.
// Latency: counters update on the edge after the strobe; a tag is visible on DOUT the cycle after its L1A.
// Backpressure: none upstream; a tag arriving at a full FIFO with no pop is dropped and OVF latches.
`timescale 1ns/1ps
module l1a_bx_tagger #(
    parameter int BX_MAX     = 3563,
    parameter int BC0_OFFSET = 0,
    parameter int DEPTH_LOG2 = 3,
    parameter int TMR        = 0
) (
    input  logic              CLKCMS,
    input  logic              clr_l1asrst,
    l1a_bx_tagger_if.slave    bus
);
    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam int          NREP    = (TMR != 0) ? 3 : 1;
    localparam logic [11:0] BX_LAST = 12'(BX_MAX);
    localparam logic [11:0] BX_LOAD = 12'(BC0_OFFSET);

    logic [11:0]           bxcnt, bx_free, bx_nxt;
    logic [23:0]           l1acnt, l1a_nxt;
    logic                  acc, do_pop, do_wr;
    logic                  empty_q, full_q, ovf_q;
    logic [DEPTH_LOG2:0]   count_q, count_nxt;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [35:0]           mem [DEPTH];
    logic [11:0]           bx_q  [NREP];
    logic [23:0]           l1a_q [NREP];

    always_comb begin
        bx_free = (bxcnt == BX_LAST) ? 12'd0 : bxcnt + 12'd1;
        bx_nxt  = bxcnt;
        if (bus.BXRST || bus.BC0)
            bx_nxt = BX_LOAD;
        else if (bus.CLKENA)
            bx_nxt = bx_free;
        acc     = bus.L1A & bus.CLKENA & ~bus.L1ASRST;
        l1a_nxt = (bus.L1ARST ? 24'd0 : l1acnt) + {23'd0, acc};
        do_pop  = bus.RD_EN & ~empty_q & ~bus.L1ASRST;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        do_wr   = acc & (~full_q | do_pop);
        case ({do_wr, do_pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge CLKCMS or posedge clr_l1asrst) begin
        if (clr_l1asrst) begin
            for (int i = 0; i < NREP; i++) begin
                bx_q[i]  <= '0;
                l1a_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREP; i++) begin
                bx_q[i]  <= bx_nxt;
                l1a_q[i] <= bus.L1ASRST ? 24'd0 : l1a_nxt;
            end
        end
    end

    generate
        if (NREP == 3) begin : g_vote
            assign bxcnt  = (bx_q[0] & bx_q[1]) | (bx_q[0] & bx_q[2]) | (bx_q[1] & bx_q[2]);
            assign l1acnt = (l1a_q[0] & l1a_q[1]) | (l1a_q[0] & l1a_q[2]) | (l1a_q[1] & l1a_q[2]);
        end else begin : g_single
            assign bxcnt  = bx_q[0];
            assign l1acnt = l1a_q[0];
        end
    endgenerate

    always_ff @(posedge CLKCMS or posedge clr_l1asrst) begin
        if (clr_l1asrst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.L1ASRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == (DEPTH_LOG2+1)'(DEPTH));
            ovf_q   <= ovf_q | (acc & full_q & ~do_pop);
        end
    end

    // Tag carries the pre-update BX: the crossing in which L1A was sampled.
    always_ff @(posedge CLKCMS) begin
        if (do_wr)
            mem[wr_ptr] <= {l1a_nxt, bxcnt};
    end

    assign bus.BXCNT  = bxcnt;
    assign bus.L1ACNT = l1acnt;
    assign bus.DOUT   = empty_q ? 36'd0 : mem[rd_ptr];
    assign bus.EMPTY  = empty_q;
    assign bus.FULL   = full_q;
    assign bus.COUNT  = count_q;
    assign bus.OVF    = ovf_q;

`ifdef BC0_CHECK_EN
    logic       bc0_err_q;
    logic [7:0] bc0_errcnt_q;

    // BC0 is expected exactly where the free-running counter would land on the offset.
    always_ff @(posedge CLKCMS or posedge clr_l1asrst) begin
        if (clr_l1asrst) begin
            bc0_err_q    <= 1'b0;
            bc0_errcnt_q <= '0;
        end else if (bus.BXRST) begin
            bc0_err_q    <= 1'b0;
            bc0_errcnt_q <= '0;
        end else if (bus.BC0 && bus.CLKENA && (bx_free != BX_LOAD)) begin
            bc0_err_q <= 1'b1;
            if (bc0_errcnt_q != 8'hFF)
                bc0_errcnt_q <= bc0_errcnt_q + 8'd1;
        end
    end

    assign bus.BC0_ERR    = bc0_err_q;
    assign bus.BC0_ERRCNT = bc0_errcnt_q;
`endif
endmodule

// File: tb/tb_l1a_bx_tagger.sv
// Directed bench for l1a_bx_tagger: reference counters plus a tag scoreboard checked on every pop.
`timescale 1ns/1ps
module tb_l1a_bx_tagger;
    localparam int DEPTH = 8;

    logic CLKCMS;
    logic clr_l1asrst;
    int   checks = 0;
    int   errors = 0;

    l1a_bx_tagger_if #(.DEPTH_LOG2(3)) bus ();

    l1a_bx_tagger #(.BX_MAX(3563), .BC0_OFFSET(0), .DEPTH_LOG2(3), .TMR(0)) dut (
        .CLKCMS      (CLKCMS),
        .clr_l1asrst (clr_l1asrst),
        .bus         (bus)
    );

    initial CLKCMS = 1'b0;
    always #12.5 CLKCMS = ~CLKCMS;

    logic [11:0] bx_m;
    logic [23:0] l1a_m;
    logic        ovf_m;
    logic [35:0] sb [$];
    logic [7:0]  errcnt_m;
    logic        err_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".bxcnt"},  64'(bus.BXCNT),  64'(bx_m));
        check({tag, ".l1acnt"}, 64'(bus.L1ACNT), 64'(l1a_m));
        check({tag, ".count"},  64'(bus.COUNT),  64'(sb.size()));
        check({tag, ".empty"},  64'(bus.EMPTY),  64'(sb.size() == 0));
        check({tag, ".full"},   64'(bus.FULL),   64'(sb.size() == DEPTH));
        check({tag, ".ovf"},    64'(bus.OVF),    64'(ovf_m));
        check({tag, ".dout"},   64'(bus.DOUT),   (sb.size() != 0) ? 64'(sb[0]) : 64'd0);
`ifdef BC0_CHECK_EN
        check({tag, ".bc0err"}, 64'(bus.BC0_ERR),    64'(err_m));
        check({tag, ".errcnt"}, 64'(bus.BC0_ERRCNT), 64'(errcnt_m));
`endif
    endtask

    // Advance one clock; reference state follows from the inputs held across the edge.
    task automatic tick();
        logic        acc;
        logic [23:0] nxt;
        logic [11:0] free;
        acc = bus.L1A & bus.CLKENA & ~bus.L1ASRST;
        if (bus.RD_EN && !bus.L1ASRST && sb.size() != 0)
            check("pop_dout", 64'(bus.DOUT), 64'(sb.pop_front()));
        nxt = (bus.L1ARST ? 24'd0 : l1a_m) + 24'(acc);
        if (bus.L1ASRST) begin
            sb.delete();
            ovf_m = 1'b0;
            l1a_m = 24'd0;
        end else begin
            if (acc) begin
                if (sb.size() < DEPTH) sb.push_back({nxt, bx_m});
                else ovf_m = 1'b1;
            end
            l1a_m = nxt;
        end
        free = (bx_m == 12'd3563) ? 12'd0 : bx_m + 12'd1;
        if (bus.BXRST) begin
            err_m = 1'b0;
            errcnt_m = 8'd0;
        end else if (bus.BC0 && bus.CLKENA && free != 12'd0) begin
            err_m = 1'b1;
            if (errcnt_m != 8'hFF) errcnt_m = errcnt_m + 8'd1;
        end
        if (bus.BXRST || bus.BC0) bx_m = 12'd0;
        else if (bus.CLKENA)      bx_m = free;
        @(negedge CLKCMS);
    endtask

    task automatic goto_bx(input logic [11:0] v);
        int n = 0;
        while (bx_m != v && n < 4000) begin
            tick();
            n++;
        end
        check("goto_bx", 64'(bus.BXCNT), 64'(v));
    endtask

    task automatic pulse_l1a();
        bus.L1A = 1'b1;
        tick();
        bus.L1A = 1'b0;
    endtask

    initial begin
        logic [11:0] bx_hold;
        logic [23:0] l1a_hold;
        bus.CLKENA = 0; bus.BC0 = 0; bus.BXRST = 0; bus.L1ARST = 0;
        bus.L1ASRST = 0; bus.L1A = 0; bus.RD_EN = 0;
        bx_m = 0; l1a_m = 0; ovf_m = 0; err_m = 0; errcnt_m = 0;
        clr_l1asrst = 1'b1;
        repeat (2) @(negedge CLKCMS);
        clr_l1asrst = 1'b0;
        check_state("reset");
        check("reset_dout", 64'(bus.DOUT), 64'd0);

        // Full BX orbit from reset: 0..3563 then wrap
        bus.CLKENA = 1'b1;
        for (int i = 0; i < 3564; i++) begin
            tick();
            check("bx_run", 64'(bus.BXCNT), 64'(bx_m));
            if (i == 3562) check("bx_max", 64'(bus.BXCNT), 64'd3563);
        end
        check("bx_wrap", 64'(bus.BXCNT), 64'd0);

        goto_bx(12'd100);
        bus.BC0 = 1'b1; tick(); bus.BC0 = 1'b0;
        check("bc0_load", 64'(bus.BXCNT), 64'd0);
        tick(); tick();
        bus.BXRST = 1'b1; bus.BC0 = 1'b1; tick(); bus.BXRST = 1'b0; bus.BC0 = 1'b0;
        check("bxrst_bc0", 64'(bus.BXCNT), 64'd0);
        check_state("after_bc0");

        // Three tagged triggers at BX 10/20/30
        goto_bx(12'd10); pulse_l1a();
        goto_bx(12'd20); pulse_l1a();
        goto_bx(12'd30); pulse_l1a();
        check("three_count", 64'(bus.COUNT), 64'd3);
        check("three_head", 64'(bus.DOUT), 64'h00000100A);
        check_state("three");
        bus.RD_EN = 1'b1; repeat (3) tick(); bus.RD_EN = 1'b0;
        check("three_empty", 64'(bus.EMPTY), 64'd1);
        check_state("three_drained");

        // Overflow: nine triggers into eight slots
        bus.L1ARST = 1'b1; tick(); bus.L1ARST = 1'b0;
        bus.L1A = 1'b1; repeat (9) tick(); bus.L1A = 1'b0;
        check("ovf_full", 64'(bus.FULL), 64'd1);
        check("ovf_flag", 64'(bus.OVF), 64'd1);
        check("ovf_l1acnt", 64'(bus.L1ACNT), 64'd9);
        check("ovf_head_evt", 64'(bus.DOUT[35:12]), 64'd1);
        check_state("ovf");
        bus.RD_EN = 1'b1; repeat (8) tick(); bus.RD_EN = 1'b0;
        check_state("ovf_drained");
        bus.RD_EN = 1'b1; tick(); bus.RD_EN = 1'b0;
        check("pop_empty_count", 64'(bus.COUNT), 64'd0);

        // L1ARST coincident with L1A, then soft reset with entries queued
        bus.L1ARST = 1'b1; tick(); bus.L1ARST = 1'b0;
        repeat (5) pulse_l1a();
        check("five_l1acnt", 64'(bus.L1ACNT), 64'd5);
        bus.L1ARST = 1'b1; bus.L1A = 1'b1; tick(); bus.L1ARST = 1'b0; bus.L1A = 1'b0;
        check("rst_and_l1a", 64'(bus.L1ACNT), 64'd1);
        check("rst_and_l1a_tag", 64'(sb[5][35:12]), 64'd1);
        bus.RD_EN = 1'b1; repeat (2) tick(); bus.RD_EN = 1'b0;
        check_state("four_queued");
        bus.L1ASRST = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.L1A = i[0];
            bus.RD_EN = i[1];
            tick();
            check("srst_l1acnt", 64'(bus.L1ACNT), 64'd0);
        end
        bus.L1ASRST = 1'b0; bus.L1A = 1'b0; bus.RD_EN = 1'b0;
        check("srst_empty", 64'(bus.EMPTY), 64'd1);
        check("srst_ovf", 64'(bus.OVF), 64'd0);
        check_state("after_srst");

        // Write while full with a simultaneous pop
        bus.L1A = 1'b1; repeat (8) tick(); bus.L1A = 1'b0;
        bus.L1A = 1'b1; bus.RD_EN = 1'b1; tick(); bus.L1A = 1'b0; bus.RD_EN = 1'b0;
        check("fullpop_count", 64'(bus.COUNT), 64'd8);
        check("fullpop_ovf", 64'(bus.OVF), 64'd0);
        check_state("fullpop");
        bus.RD_EN = 1'b1; repeat (8) tick(); bus.RD_EN = 1'b0;
        check_state("fullpop_drained");

        // CLKENA low: counters hold, L1A ignored, BC0 still loads
        bx_hold = bx_m; l1a_hold = l1a_m;
        bus.CLKENA = 1'b0;
        pulse_l1a();
        check("hold_bx", 64'(bus.BXCNT), 64'(bx_hold));
        check("hold_l1a", 64'(bus.L1ACNT), 64'(l1a_hold));
        check("hold_empty", 64'(bus.EMPTY), 64'd1);
        bus.BC0 = 1'b1; tick(); bus.BC0 = 1'b0;
        check("bc0_noena", 64'(bus.BXCNT), 64'd0);
        bus.CLKENA = 1'b1;
        check_state("clkena");

`ifdef BC0_CHECK_EN
        goto_bx(12'd3563);
        bus.BC0 = 1'b1; tick(); bus.BC0 = 1'b0;
        check("bc0_aligned_err", 64'(bus.BC0_ERR), 64'd0);
        goto_bx(12'd500);
        bus.BC0 = 1'b1; tick(); bus.BC0 = 1'b0;
        check("bc0_misaligned_err", 64'(bus.BC0_ERR), 64'd1);
        check("bc0_misaligned_cnt", 64'(bus.BC0_ERRCNT), 64'd1);
        bus.BXRST = 1'b1; tick(); bus.BXRST = 1'b0;
        check("bxrst_err", 64'(bus.BC0_ERR), 64'd0);
        check("bxrst_cnt", 64'(bus.BC0_ERRCNT), 64'd0);
        check_state("bc0_check");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l1a_bx_tagger.md
Name: l1a_bx_tagger

Overview:
Downstream consumer of the CCB command decoder outputs (BX0/BC0, BXRST, L1ARST, L1ASRST, CLKENA). It maintains the local bunch-crossing counter and the L1A event counter. On every L1A it tags the event with {event number, BX number} and buffers the tag in a small first-word-fall-through (FWFT) FIFO for the DAQ header builder.

Parameters:
BX_MAX, 3563, last valid BX number; counter wraps BX_MAX -> 0.
BC0_OFFSET, 0, value loaded into the BX counter on BC0/BXRST.
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (default 8).
TMR, 0, passed to counter primitives (1 = triplicated registers); no functional change.

Ports:
CLKCMS  input  1  40 MHz LHC clock; all logic rising-edge.
clr_l1asrst  input  1  reset, asynchronous, active-high.
CLKENA  input  1  counting enable; when low, neither counter advances and L1A is ignored.
BC0  input  1  bunch-crossing-zero strobe, one cycle.
BXRST  input  1  BX counter reset strobe.
L1ARST  input  1  L1A counter reset strobe, one cycle.
L1ASRST  input  1  L1A soft reset, level, typically high for 16 cycles.
L1A  input  1  level-1 accept, one cycle per trigger.
RD_EN  input  1  pop request from the header builder.
BXCNT  output  12  current BX number.
L1ACNT  output  24  events accepted since the last L1A reset.
DOUT  output  36  FIFO head: {L1A number[35:12], BX number[11:0]}.
EMPTY  output  1  FIFO empty.
FULL  output  1  FIFO full.
COUNT  output  DEPTH_LOG2+1  FIFO occupancy.
OVF  output  1  sticky: an L1A tag was dropped because the FIFO was full.

Behaviour:
- Reset (clr_l1asrst high, async): BXCNT=0, L1ACNT=0, FIFO pointers=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, DOUT=0.
- BX counter, per cycle in priority order:
  - BXRST or BC0 -> BC0_OFFSET.
  - else if CLKENA: BXCNT==BX_MAX -> 0, otherwise BXCNT+1.
  - else hold.
  - BXRST/BC0 take effect even when CLKENA is low.
- L1A counter:
  - Effective accept: acc = L1A & CLKENA & ~L1ASRST.
  - Next value: nxt = (L1ARST ? 0 : L1ACNT) + acc, modulo 2^24 (0xFFFFFF wraps to 0).
  - L1ARST together with L1A gives L1ACNT=1.
  - While L1ASRST is high: L1ACNT forced to 0 and acc is 0.
- Tag write:
  - When acc=1, write {nxt, BXCNT} to the FIFO. BXCNT is the value before this cycle's update, so the tag is the crossing in which L1A was sampled.
  - The first L1A after reset is tagged with event number 1.
- FIFO: FWFT.
  - Write at edge N -> EMPTY=0 and DOUT valid after edge N.
  - DOUT always shows the head entry; RD_EN with EMPTY=0 pops it and the next entry appears the following cycle.
  - RD_EN while EMPTY=1 is ignored.
  - Write while FULL with no pop: tag dropped, OVF=1. L1ACNT still increments, so downstream sees a gap in event numbers.
  - Write while FULL with a simultaneous pop: write accepted, COUNT unchanged, OVF unchanged.
  - Simultaneous read and write in any other state: COUNT unchanged.
  - Pointers wrap modulo depth. FULL = (COUNT==depth), EMPTY = (COUNT==0), both registered with COUNT.
- L1ASRST high: FIFO flushed (pointers and COUNT to 0, EMPTY=1, FULL=0) and OVF cleared, every cycle it is high. Pops during L1ASRST are ignored.
- BXCNT is not affected by L1ARST or L1ASRST.

Optional Feature:
BC0_CHECK_EN
- Defined: extra outputs BC0_ERR (1 bit, sticky) and BC0_ERRCNT (8 bits, saturating at 0xFF).
  - On BC0 with CLKENA=1 while BXRST=0: if the value BXCNT would have taken without the load is not equal to BC0_OFFSET, BC0_ERR is set and BC0_ERRCNT incremented. The BX counter is then reloaded as normal.
  - Both cleared by clr_l1asrst or BXRST.
- Undefined: ports absent, no check logic; BC0 only reloads the counter.

Test Plan:
- Pulse clr_l1asrst, then CLKENA=1 for 3564 cycles with no BC0 -> BXCNT runs 0..3563 then 0; all outputs at reset values immediately after reset.
- BC0 when BXCNT=100 -> BXCNT=0 next cycle. BXRST and BC0 in the same cycle -> BXCNT=BC0_OFFSET.
- Three L1As with BXCNT at 10, 20, 30, no reads -> COUNT=3; DOUT={1,10}; RD_EN x3 pops {1,10},{2,20},{3,30}; then EMPTY=1.
- Nine L1As, no reads, depth 8 -> FULL=1, OVF=1, L1ACNT=9. Pop all -> 8 tags with event numbers 1..8.
- L1ARST and L1A in the same cycle with L1ACNT=5 -> L1ACNT=1, tag event number 1. L1ASRST held 16 cycles with 4 entries queued -> EMPTY=1, OVF=0, L1ACNT=0; L1As during that window are ignored.
- With BC0_CHECK_EN: BC0 at BXCNT=3563 -> no error. BC0 at BXCNT=500 -> BC0_ERR=1, BC0_ERRCNT=1. Then BXRST -> both cleared.
